// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Types and constants shared by the 2-cycle ALU and its result FIFO.
//   operation_t  : ALU operation encoding (nop/add/sub)
//   ALU_LATENCY  : cycles from issue to out_valid; bounds the in-flight credit
//   ALU_IFW      : width of a counter that holds 0..ALU_LATENCY
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_LATENCY = 2;
    localparam int ALU_IFW     = $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } operation_t;

endpackage

// File: rtl/res_fifo_mem.sv
// ---------------------------------------------------------------------------
// res_fifo_mem
// DEPTH x WIDTH register array with one synchronous write port and an
// asynchronous read port. The array clears on reset so the read port shows
// zero until something is written.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  mem[raddr_i], combinational
// ---------------------------------------------------------------------------
module res_fifo_mem
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array: cleared on reset, one entry written per enabled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// Absorbs every ALU result (no backpressure on the ALU side) into a
// DEPTH-entry FIFO and re-presents it on a valid/ready master port. A credit
// counter tracks ops still inside the ALU so the issuer is only told issue_ok
// when the result is guaranteed a slot.
// Optional build macro: ALU_RESFIFO_OVF_EN adds a sticky overflow output and
// an internal 16-bit saturating drop counter (drop_cnt_q).
// Ports:
//   clk, rst      clock (rising) / asynchronous active-high reset
//   issue_fire    upstream issued an op into the ALU this cycle
//   issue_ok      (count + in_flight) < DEPTH, from registers only
//   res_in        ALU result data
//   res_valid_in  ALU result valid
//   m_data        FIFO head data
//   m_valid       FIFO non-empty
//   m_ready       consumer accepts the head
//   overflow      (macro only) sticky: a result was dropped
//   count         occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_fire,
    output logic                     issue_ok,
    input  logic [WIDTH-1:0]         res_in,
    input  logic                     res_valid_in,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
`ifdef ALU_RESFIFO_OVF_EN
    output logic                     overflow,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ALU_IFW-1:0] in_flight_q, in_flight_d;
    logic [SW-1:0]      credit_sum_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;

    assign full_s = (count_q == CW'(DEPTH));
    assign pop_s  = m_valid && m_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_s = res_valid_in && (!full_s || pop_s);
    assign drop_s = res_valid_in && full_s && !pop_s;

    // Next-state for pointers, occupancy and ALU credit.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        in_flight_d = in_flight_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Guards keep the credit sane if upstream breaks protocol.
        case ({issue_fire, res_valid_in})
            2'b10: begin
                if (in_flight_q != '1) begin
                    in_flight_d = in_flight_q + ALU_IFW'(1);
                end else begin
                    in_flight_d = in_flight_q;
                end
            end
            2'b01: begin
                if (in_flight_q != '0) begin
                    in_flight_d = in_flight_q - ALU_IFW'(1);
                end else begin
                    in_flight_d = in_flight_q;
                end
            end
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Pointer, occupancy and credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
        end
    end

    // Results already stored plus those still in the ALU must fit.
    assign credit_sum_s = SW'(count_q) + SW'(in_flight_q);
    assign issue_ok     = (credit_sum_s < SW'(DEPTH));
    assign m_valid      = (count_q != '0);
    assign count        = count_q;

    res_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (res_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (m_data)
    );

`ifdef ALU_RESFIFO_OVF_EN
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Sticky drop flag and saturating drop counter next-state.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop tracking registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule
